systolic_pe: RTL and testbench
==============================

SYSTOLIC_PE -- requirements
Module: systolic_pe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: operand width, signed two's complement.
REQ-002 SHALL have parameter ACC_WIDTH, default 40: accumulator width; ACC_WIDTH >= 2*DATA_WIDTH (elaboration error otherwise).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports a_in, b_in  input  DATA_WIDTH  west/north operands.
REQ-006 SHALL have port in_valid  input  1  a_in/b_in valid this cycle.
REQ-007 SHALL have port clear  input  1  zero accumulator without output.
REQ-008 SHALL have port drain  input  1  request result output and accumulator restart.
REQ-009 SHALL have ports a_out, b_out  output  DATA_WIDTH  registered operand pass-through to east/south neighbours.
REQ-010 SHALL have port out_valid  output  1  registered copy of in_valid.
REQ-011 SHALL have port c_out  output  ACC_WIDTH  drained result.
REQ-012 SHALL have port c_valid  output  1  c_out valid, one-cycle pulse.
REQ-013 SHALL have port c_sat  output  1  saturation occurred in drained result.
REQ-014 SHALL have port busy  output  1  drain in progress.

Function
REQ-015 Pass-through SHALL be unconditional: each edge a_out<=a_in, b_out<=b_in, out_valid<=in_valid, regardless of state.
REQ-016 Zero operands SHALL be treated as valid data (no skip).
REQ-017 Stage 1: edge k with in_valid=1 and busy=0 SHALL register full-precision signed product a_in*b_in (2*DATA_WIDTH) and a product-valid bit.
REQ-018 Stage 2: edge k+1 SHALL add the sign-extended product into the accumulator.
REQ-019 Addition SHALL saturate to signed ACC_WIDTH max/min; any saturation SHALL set a sticky internal sat flag.
REQ-020 FSM states: ACCUM, FLUSH, DONE; reset state ACCUM; busy=1 in FLUSH and DONE.
REQ-021 ACCUM->FLUSH when drain=1 sampled; FLUSH->DONE next edge; DONE->ACCUM next edge.
REQ-022 A sample taken in the same edge as drain SHALL be included in the result.
REQ-023 On DONE->ACCUM edge: c_out<=accumulator, c_sat<=sat flag, c_valid<=1, accumulator<=0, sat flag<=0.
REQ-024 c_valid SHALL be high exactly one cycle, first visible after the second edge following the edge sampling drain; c_out, c_sat SHALL hold until the next drain.
REQ-025 in_valid while busy SHALL not enter stage 1 (still passed through).
REQ-026 drain and clear while busy SHALL be ignored.
REQ-027 clear in ACCUM at edge k: accumulator and sat flag <=0, discarding any stage-2 add at k; stage-1 capture at k proceeds and is accumulated at k+1.
REQ-028 clear and drain both asserted in ACCUM: drain SHALL win, clear ignored.

Reset
REQ-029 rst SHALL take priority over all inputs, any state.
REQ-030 On rst: a_out, b_out, c_out=0; out_valid, c_valid, c_sat, busy=0; accumulator, product register, product-valid, sat flag=0; state ACCUM.
REQ-031 rst mid-FLUSH/DONE SHALL abort the drain with no c_valid pulse.

Verification
REQ-032 Reset: drive rst 2 cycles with random inputs -> all outputs 0, busy=0.
REQ-033 Pass-through: a_in=3, b_in=5, in_valid=1 at edge k -> a_out=3, b_out=5, out_valid=1 after k.
REQ-034 Accumulate: (2,3),(-4,5),(0,7) consecutive, drain with third sample -> c_out=-14, c_sat=0, c_valid single pulse two edges after drain; next drain with no inputs -> c_out=0.
REQ-035 Saturation (ACC_WIDTH=32): two samples (-32768,-32768), drain -> c_out=2147483647, c_sat=1; following drain -> c_sat=0.
REQ-036 Busy/clear: accumulate (10,10), clear with sample (2,2), drain -> c_out=4; in_valid (9,9) and second drain during busy -> ignored, next drain c_out=0.
REQ-037 Reset mid-FLUSH: accumulate (7,7), drain, rst next cycle -> no c_valid, c_out=0; subsequent (1,1)+drain -> c_out=1.

Source files
------------

// File: rtl/systolic_pe_if.sv
// Operand, control and result signals of one systolic processing element.
// The master modport belongs to whatever feeds the PE; the slave modport belongs to the PE itself.
interface systolic_pe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
);
  logic signed [DATA_WIDTH-1:0] a_in;
  logic signed [DATA_WIDTH-1:0] b_in;
  logic                         in_valid;
  logic                         clear;
  logic                         drain;
  logic signed [DATA_WIDTH-1:0] a_out;
  logic signed [DATA_WIDTH-1:0] b_out;
  logic                         out_valid;
  logic signed [ACC_WIDTH-1:0]  c_out;
  logic                         c_valid;
  logic                         c_sat;
  logic                         busy;

  modport master (
    output a_in, b_in, in_valid, clear, drain,
    input  a_out, b_out, out_valid, c_out, c_valid, c_sat, busy
  );

  modport slave (
    input  a_in, b_in, in_valid, clear, drain,
    output a_out, b_out, out_valid, c_out, c_valid, c_sat, busy
  );
endinterface

// File: rtl/systolic_pe.sv
// Systolic-array processing element: a two-stage signed multiply-accumulate with saturation,
// plus registered operand pass-through and a drain sequence that emits the result.
module systolic_pe #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
) (
  input logic        clk,
  input logic        rst,
  systolic_pe_if.slave pe
);
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  generate
    if (ACC_WIDTH < PROD_WIDTH) begin : g_width_check
      $error("systolic_pe: ACC_WIDTH must be at least 2*DATA_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {ACCUM, FLUSH, DONE} state_t;

  state_t state;
  state_t state_next;

  logic busy_int;
  logic capture;
  logic do_clear;
  logic finish;

  logic signed [PROD_WIDTH-1:0] product;
  logic                         product_valid;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic                         sat;
  logic signed [ACC_WIDTH:0]    sum_wide;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic                         sum_ovf;

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (pe.drain) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      DONE:    state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Drain beats clear; both are ignored outside ACCUM, and new samples are refused while busy.
  always_comb begin
    busy_int = (state != ACCUM);
    capture  = pe.in_valid && !busy_int;
    do_clear = (state == ACCUM) && pe.clear && !pe.drain;
    finish   = (state == DONE);
  end

  assign pe.busy = busy_int;

  always_ff @(posedge clk) begin
    if (rst) begin
      pe.a_out     <= '0;
      pe.b_out     <= '0;
      pe.out_valid <= 1'b0;
    end else begin
      pe.a_out     <= pe.a_in;
      pe.b_out     <= pe.b_in;
      pe.out_valid <= pe.in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      product       <= '0;
      product_valid <= 1'b0;
    end else begin
      product_valid <= capture;
      if (capture) product <= PROD_WIDTH'(pe.a_in) * PROD_WIDTH'(pe.b_in);
    end
  end

  // One guard bit on the sum exposes signed overflow as a mismatch of the top two bits.
  always_comb begin
    sum_wide = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(product);
    sum_ovf  = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
    if (!sum_ovf)                acc_sum = sum_wide[ACC_WIDTH-1:0];
    else if (sum_wide[ACC_WIDTH]) acc_sum = ACC_MIN;
    else                          acc_sum = ACC_MAX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      sat        <= 1'b0;
      pe.c_out   <= '0;
      pe.c_sat   <= 1'b0;
      pe.c_valid <= 1'b0;
    end else begin
      pe.c_valid <= 1'b0;
      if (finish) begin
        pe.c_out   <= acc;
        pe.c_sat   <= sat;
        pe.c_valid <= 1'b1;
        acc        <= '0;
        sat        <= 1'b0;
      end else if (do_clear) begin
        acc <= '0;
        sat <= 1'b0;
      end else if (product_valid) begin
        acc <= acc_sum;
        sat <= sat | sum_ovf;
      end
    end
  end
endmodule

// File: tb/tb_systolic_pe.sv
// Randomised scoreboard bench for systolic_pe: the driver predicts results from the list of
// accepted samples per drain window; a monitor pops predictions whenever the PE responds.
module tb_systolic_pe;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam longint ACC_MAX = (longint'(1) <<< (AW - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (AW - 1));

  typedef struct {
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    bit                   v;
    bit                   busy;
    bit                   rst;
  } pt_t;

  typedef struct {
    longint c;
    bit     sat;
    int     due;
  } res_t;

  logic clk;
  logic rst;

  systolic_pe_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) pe_if ();

  systolic_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .pe  (pe_if)
  );

  pt_t    pt_q[$];
  res_t   res_q[$];
  longint win[$];
  int     phase;
  int     edge_no;
  int     total;
  int     bad;
  longint held_c;
  bit     held_sat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic signed [63:0] act,
                              input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  // Each product is added in arrival order, clamping after every addition.
  function automatic res_t reduce_window(input int due);
    res_t r;
    longint s;
    r.c   = 0;
    r.sat = 1'b0;
    r.due = due;
    foreach (win[i]) begin
      s = r.c + win[i];
      if (s > ACC_MAX) begin s = ACC_MAX; r.sat = 1'b1; end
      else if (s < ACC_MIN) begin s = ACC_MIN; r.sat = 1'b1; end
      r.c = s;
    end
    return r;
  endfunction

  task automatic apply_stimulus(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                                input bit v, input bit clr, input bit drn, input bit r);
    int  e;
    bit  busy_after;
    pt_t p;
    e = edge_no + 1;
    pe_if.a_in     = a;
    pe_if.b_in     = b;
    pe_if.in_valid = v;
    pe_if.clear    = clr;
    pe_if.drain    = drn;
    rst            = r;
    busy_after     = 1'b0;
    if (r) begin
      phase = 0;
      win.delete();
      res_q.delete();
      p = '{a: '0, b: '0, v: 1'b0, busy: 1'b0, rst: 1'b1};
    end else begin
      if (phase > 0) begin
        phase--;
        busy_after = (phase > 0);
      end else if (drn) begin
        if (v) win.push_back(longint'(a) * longint'(b));
        res_q.push_back(reduce_window(e + 2));
        win.delete();
        phase      = 2;
        busy_after = 1'b1;
      end else begin
        if (clr) win.delete();
        if (v) win.push_back(longint'(a) * longint'(b));
      end
      p = '{a: a, b: b, v: v, busy: busy_after, rst: 1'b0};
    end
    pt_q.push_back(p);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(posedge clk) begin
    pt_t  p;
    res_t r;
    #1;
    edge_no++;
    if (pt_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL stim_queue: got empty, expected an entry (edge %0d)", edge_no);
    end else begin
      p = pt_q.pop_front();
      check_output("a_out", pe_if.a_out, p.a);
      check_output("b_out", pe_if.b_out, p.b);
      check_output("out_valid", pe_if.out_valid, p.v);
      check_output("busy", pe_if.busy, p.busy);
      if (p.rst) begin
        held_c   = 0;
        held_sat = 1'b0;
      end
    end
    if (pe_if.c_valid === 1'b1) begin
      if (res_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL c_valid: got unexpected pulse, expected none (edge %0d)", edge_no);
      end else begin
        r = res_q.pop_front();
        check_output("c_valid_timing", edge_no, r.due);
        held_c   = r.c;
        held_sat = r.sat;
        check_output("c_out", pe_if.c_out, held_c);
        check_output("c_sat", pe_if.c_sat, held_sat);
      end
    end else begin
      check_output("c_valid", pe_if.c_valid, 1'b0);
      if (res_q.size() != 0 && res_q[0].due <= edge_no) begin
        r = res_q.pop_front();
        total++;
        bad++;
        $display("[TB] FAIL c_valid_missing: got no pulse, expected c_out=%0d at edge %0d",
                 r.c, r.due);
        held_c   = r.c;
        held_sat = r.sat;
      end else begin
        check_output("c_out_hold", pe_if.c_out, held_c);
        check_output("c_sat_hold", pe_if.c_sat, held_sat);
      end
    end
  end

  initial begin
    logic signed [DW-1:0] ra;
    logic signed [DW-1:0] rb;
    total    = 0;
    bad      = 0;
    edge_no  = 0;
    phase    = 0;
    held_c   = 0;
    held_sat = 1'b0;

    for (int i = 0; i < 2; i++)
      apply_stimulus(DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);

    apply_stimulus(16'sd3, 16'sd5, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus('0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    apply_stimulus(16'sd2, 16'sd3, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(-16'sd4, 16'sd5, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(16'sd0, 16'sd7, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);

    apply_stimulus(-16'sd32768, -16'sd32768, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(-16'sd32768, -16'sd32768, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);

    apply_stimulus(16'sd10, 16'sd10, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(16'sd2, 16'sd2, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(16'sd9, 16'sd9, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);

    apply_stimulus(16'sd7, 16'sd7, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    apply_stimulus(16'sd1, 16'sd1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ra = DW'(int'($urandom_range(0, 20)) - 10);
        rb = DW'(int'($urandom_range(0, 20)) - 10);
      end else begin
        ra = DW'($urandom);
        rb = DW'($urandom);
      end
      apply_stimulus(ra, rb, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                     $urandom_range(0, 11) == 0, $urandom_range(0, 99) == 0);
    end

    idle(4);
    check_output("pending_results", res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
